axi4lite_regbank_slave: RTL and testbench

//  Parametrised AXI4-Lite slave register bank; next generation of the tiny 2-bit/8-bit AXI4-Lite demo register file.

---
 rtl/axi4lite_pkg.sv | 14 +
 rtl/axi4lite_hold_slot.sv | 33 +++
 rtl/axi4lite_regbank_slave.sv | 163 ++++++++++++++++
 tb/tb_axi4lite_regbank_slave.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and the byte-lane merge used by the register bank.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One byte lane: take the new byte when its strobe is set, otherwise keep the old one.
    function automatic logic [7:0] strb_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       strb);
        return strb ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/axi4lite_hold_slot.sv
// Single-entry valid+payload holding register for one AXI4-Lite channel beat.
module axi4lite_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Clear wins: a beat that handshakes on the commit edge is consumed directly, never held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/axi4lite_regbank_slave.sv
// Parametrised AXI4-Lite register bank: independent AW/W slots, WSTRB lanes,
// SLVERR on unmapped addresses, flat register view and per-register write pulses.
module axi4lite_regbank_slave
    import axi4lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int SLOT_W   = STRB_W + DATA_WIDTH;
    localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_ready_en;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic                  w_aw_held, w_w_held, w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0] w_aw_held_addr, w_wr_addr;
    logic [SLOT_W-1:0]     w_w_held_payload;
    logic [DATA_WIDTH-1:0] w_wr_data, w_wr_old, w_wr_new, w_rd_val;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
    logic                  w_wr_in_range, w_rd_in_range;
    logic                  w_unused_addr_lsbs;

    // Readies stay low for the first cycle after reset so every output reads 0 while in reset.
    assign s_awready = r_ready_en & ~w_aw_held & ~r_bvalid;
    assign s_wready  = r_ready_en & ~w_w_held & ~r_bvalid;
    assign s_arready = r_ready_en & ~r_rvalid;

    assign w_aw_hs  = s_awvalid & s_awready;
    assign w_w_hs   = s_wvalid & s_wready;
    assign w_ar_hs  = s_arvalid & s_arready;
    assign w_commit = (w_aw_held | w_aw_hs) & (w_w_held | w_w_hs);

    axi4lite_hold_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_aw_hs),
        .i_clear (w_commit),
        .i_data  (s_awaddr),
        .o_valid (w_aw_held),
        .o_data  (w_aw_held_addr)
    );

    axi4lite_hold_slot #(.WIDTH(SLOT_W)) u_w_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_w_hs),
        .i_clear (w_commit),
        .i_data  ({s_wstrb, s_wdata}),
        .o_valid (w_w_held),
        .o_data  (w_w_held_payload)
    );

    assign w_wr_addr              = w_aw_held ? w_aw_held_addr : s_awaddr;
    assign {w_wr_strb, w_wr_data} = w_w_held ? w_w_held_payload : {s_wstrb, s_wdata};

    assign w_wr_idx      = w_wr_addr[ADDR_WIDTH-1:ADDR_LSB];
    assign w_rd_idx      = s_araddr[ADDR_WIDTH-1:ADDR_LSB];
    assign w_wr_in_range = {1'b0, w_wr_idx} < NUM_REGS_L;
    assign w_rd_in_range = {1'b0, w_rd_idx} < NUM_REGS_L;

    // Byte-offset bits never take part in the decode.
    assign w_unused_addr_lsbs = ^{s_araddr, w_wr_addr};

    // NOTE: combinational blocks use blocking '=' with every output defaulted first; no latches.
    always_comb begin
        w_wr_old = '0;
        w_rd_val = '0;
        w_wr_new = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_idx == IDX_W'(i)) w_wr_old = r_regs[i];
            if (w_rd_idx == IDX_W'(i)) w_rd_val = r_regs[i];
        end
        for (int k = 0; k < STRB_W; k++) begin
            w_wr_new[k*8 +: 8] = strb_merge(w_wr_old[k*8 +: 8], w_wr_data[k*8 +: 8], w_wr_strb[k]);
        end
    end

    // NOTE: the register array is reset because its contents are architecturally visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_en <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
        end else begin
            r_ready_en <= 1'b1;
            r_wr_pulse <= '0;

            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_wr_in_range && w_wr_idx == IDX_W'(i)) begin
                        r_regs[i]     <= w_wr_new;
                        r_wr_pulse[i] <= 1'b1;
                    end
                end
            end else if (s_bready) begin
                r_bvalid <= 1'b0;
            end

            // Reads sample the pre-commit register value on a shared edge.
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                r_rdata  <= w_rd_in_range ? w_rd_val : '0;
            end else if (s_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    assign s_bvalid   = r_bvalid;
    assign s_bresp    = r_bresp;
    assign s_rvalid   = r_rvalid;
    assign s_rresp    = r_rresp;
    assign s_rdata    = r_rdata;
    assign wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_axi4lite_regbank_slave.sv
// Directed bench: a 4-register and a 3-register bank share one stimulus stream.
module tb_axi4lite_regbank_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bready = 1'b1, rready = 1'b1;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [127:0] regs;
    logic [3:0]  wr_pulse;

    logic        awready3, wready3, bvalid3, arready3, rvalid3;
    logic [1:0]  bresp3, rresp3;
    logic [31:0] rdata3;
    logic [95:0] regs3;
    logic [2:0]  wr_pulse3;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  cap_bresp, cap_bresp3, cap_rresp, cap_rresp3;
    logic        cap_bvalid, cap_rvalid;
    logic [3:0]  cap_pulse, cap_pulse_next;
    logic [2:0]  cap_pulse3;
    logic [31:0] cap_rdata, cap_rdata3;

    always #5 clk = ~clk;

    axi4lite_regbank_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(4)) u_dut (
        .clk(clk), .rst(rst),
        .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready),
        .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
        .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready),
        .s_rdata(rdata), .s_rresp(rresp), .s_rvalid(rvalid), .s_rready(rready),
        .regs_o(regs), .wr_pulse_o(wr_pulse)
    );

    axi4lite_regbank_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(3),
                             .RESET_VALUE(32'h5A5A_0000)) u_dut3 (
        .clk(clk), .rst(rst),
        .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready3),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready3),
        .s_bresp(bresp3), .s_bvalid(bvalid3), .s_bready(bready),
        .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready3),
        .s_rdata(rdata3), .s_rresp(rresp3), .s_rvalid(rvalid3), .s_rready(rready),
        .regs_o(regs3), .wr_pulse_o(wr_pulse3)
    );

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [3:0]  exp_pulse;
        logic [3:0]  raddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AW and W together; captures the response cycle and, if bready is high, the following one.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        check("wr_ready_seen", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        cap_bvalid = bvalid; cap_bresp = bresp; cap_pulse = wr_pulse;
        cap_bresp3 = bresp3; cap_pulse3 = wr_pulse3;
        cap_pulse_next = 'x;
        if (bready) begin
            tick();
            cap_pulse_next = wr_pulse;
        end
    endtask

    task automatic do_read(input logic [3:0] a);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        check("rd_ready_seen", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        cap_rvalid = rvalid; cap_rdata = rdata; cap_rresp = rresp;
        cap_rdata3 = rdata3; cap_rresp3 = rresp3;
        if (rready) tick();
    endtask

    initial begin
        vecs[0] = '{4'h8, 32'hDEAD_BEEF, 4'hF, 2'b00, 4'b0100, 4'h8, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{4'h0, 32'h1234_5678, 4'hF, 2'b00, 4'b0001, 4'h0, 32'h1234_5678, 2'b00};
        vecs[2] = '{4'hE, 32'hCAFE_F00D, 4'hC, 2'b00, 4'b1000, 4'hF, 32'hCAFE_0000, 2'b00};
        vecs[3] = '{4'h9, 32'h0000_0000, 4'h0, 2'b00, 4'b0100, 4'h8, 32'hDEAD_BEEF, 2'b00};
        vecs[4] = '{4'h0, 32'hFFFF_FFFF, 4'h3, 2'b00, 4'b0001, 4'h2, 32'h1234_FFFF, 2'b00};

        // Reset state
        repeat (2) tick();
        check("rst_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, wr_pulse}, '0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_regs", regs[63:0] | regs[127:64], 64'h0);
        check("rst_regs3", regs3[31:0] & regs3[63:32] & regs3[95:64], 32'h5A5A_0000);
        rst = 1'b0;
        tick();

        // Table: write then read back (entry 0 is AW+W same cycle with bready high)
        for (int i = 0; i < 5; i++) begin
            do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
            check($sformatf("v%0d_bvalid", i), cap_bvalid, 1'b1);
            check($sformatf("v%0d_bresp", i), cap_bresp, vecs[i].exp_bresp);
            check($sformatf("v%0d_pulse", i), cap_pulse, vecs[i].exp_pulse);
            check($sformatf("v%0d_pulse_gone", i), cap_pulse_next, 4'b0000);
            check($sformatf("v%0d_bvalid_clr", i), bvalid, 1'b0);
            do_read(vecs[i].raddr);
            check($sformatf("v%0d_rdata", i), cap_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_rresp", i), cap_rresp, vecs[i].exp_rresp);
        end

        // W three cycles ahead of AW
        wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("w_first_wready", wready, 1'b0);
        check("w_first_awready", awready, 1'b1);
        tick(); tick();
        check("w_first_no_commit", {bvalid, regs[63:32]}, {1'b0, 32'h0});
        awaddr = 4'h4; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("w_first_bvalid", {bvalid, bresp}, {1'b1, 2'b00});
        check("w_first_reg1", regs[63:32], 32'h1122_3344);
        check("w_first_pulse", wr_pulse, 4'b0010);
        tick();

        // Partial strobes on reg1
        do_write(4'h4, 32'hAABB_CCDD, 4'b0101);
        check("strb_reg1", regs[63:32], 32'h11BB_33DD);

        // Unmapped address on the 3-register bank
        do_write(4'hC, 32'h55AA_55AA, 4'hF);
        check("oor_bresp3", cap_bresp3, 2'b10);
        check("oor_pulse3", cap_pulse3, 3'b000);
        check("oor_bresp4", cap_bresp, 2'b00);
        check("oor_regs3", regs3, {32'hDEAD_BEEF, 32'h11BB_33DD, 32'h1234_FFFF});
        do_read(4'hC);
        check("oor_rd3", {cap_rresp3, cap_rdata3}, {2'b10, 32'h0});
        check("oor_rd4", {cap_rresp, cap_rdata}, {2'b00, 32'h55AA_55AA});

        // Backpressure on B and R
        bready = 1'b0;
        do_write(4'h0, 32'h0BAD_F00D, 4'hF);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bstall%0d", c), {bvalid, bresp, awready, wready}, {1'b1, 2'b00, 2'b00});
        end
        bready = 1'b1;
        tick();
        check("bstall_release", bvalid, 1'b0);
        rready = 1'b0;
        do_read(4'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("rstall%0d", c), {rvalid, rresp, arready, rdata}, {1'b1, 2'b00, 1'b0, 32'h0BAD_F00D});
        end
        rready = 1'b1;
        tick();
        check("rstall_release", rvalid, 1'b0);

        // Read and write of reg2 on the same edge returns the old value
        awaddr = 4'h8; wdata = 32'h0102_0304; wstrb = 4'hF; araddr = 4'h8;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_edge_rdata", rdata, 32'hDEAD_BEEF);
        check("same_edge_reg2", regs[95:64], 32'h0102_0304);
        tick();

        // Reset with AW held and R pending
        rready = 1'b0;
        do_read(4'h8);
        check("pre_rst_rvalid", cap_rvalid, 1'b1);
        awaddr = 4'h4; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("pre_rst_aw_held", awready, 1'b0);
        rst = 1'b1;
        tick();
        check("mid_rst_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, wr_pulse}, '0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_regs", regs[63:0] | regs[127:64], 64'h0);
        check("mid_rst_regs3", regs3, {3{32'h5A5A_0000}});
        rst = 1'b0; rready = 1'b1;
        tick();
        check("post_rst_awready", awready, 1'b1);
        wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick(); tick();
        check("post_rst_no_commit", {bvalid, wr_pulse}, 5'b0);
        check("post_rst_regs", regs[63:0] | regs[127:64], 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
